// File: rtl/mul_hilo_ctrl.sv
// Issue/writeback controller around a fixed-latency unsigned 32x32 multiplier.
// Holds operands stable, waits LATENCY cycles, sign-corrects and writes HI/LO.
module mul_hilo_ctrl #(
  parameter int LATENCY = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [63:0] prod;

  // Magnitudes wrap, so 0x80000000 stays 0x80000000 and reads as unsigned 2^31.
  assign abs_rs = rs[31] ? (~rs + 32'd1) : rs;
  assign abs_rt = rt[31] ? (~rt + 32'd1) : rt;
  assign prod   = neg_q ? (~mul_z + 64'd1) : mul_z;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_MULTU: begin
              mul_a_d = rs;
              mul_b_d = rt;
              neg_d   = 1'b0;
              cnt_d   = '0;
              state_d = ST_WAIT;
            end
            OP_MULT: begin
              mul_a_d = abs_rs;
              mul_b_d = abs_rt;
              neg_d   = rs[31] ^ rt[31];
              cnt_d   = '0;
              state_d = ST_WAIT;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q + CNT_ONE;
        // mul_z has been valid for one cycle by the time cnt reaches LATENCY.
        if (cnt_q == CNT_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_WAIT);
  assign done      = done_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl with a behavioural 6-stage multiplier and a
// scoreboard of expected {hi,lo} values checked on every done pulse.
module tb_mul_hilo_ctrl;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int mul_count = 0;
  logic [63:0] sb[$];
  logic [63:0] pipe[LAT];

  mul_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .rs(rs), .rt(rt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pipelined unsigned multiplier sharing the reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_z = pipe[LAT-1];

  // Scoreboard: every done pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=1 with no multiply outstanding, hi=%h lo=%h", hi, lo);
      end else begin
        exp_v = sb.pop_front();
        mul_count++;
        if ({hi, lo} !== exp_v) begin
          errors++;
          $display("FAIL hilo_result: got hi=%h lo=%h, expected hi=%h lo=%h",
                   hi, lo, exp_v[63:32], exp_v[31:0]);
        end else begin
          $display("mul #%0d writeback hi=%h lo=%h", mul_count, hi, lo);
        end
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    if (op == 2'b00) return {32'b0, a} * {32'b0, b};
    return sa * sbv;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    rs        = a;
    rt        = b;
    if (!op[1]) sb.push_back(model(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    rs = '0;
    rt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: hi=%h lo=%h mul_a=%h mul_b=%h, expected all 0", hi, lo, mul_a, mul_b);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: req_ready=%b busy=%b done=%b, expected 1 0 0", req_ready, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    int cyc;
    logic [31:0] ea;
    logic [31:0] eb;
    ea = (op == 2'b01 && a[31]) ? (32'd0 - a) : a;
    eb = (op == 2'b01 && b[31]) ? (32'd0 - b) : b;
    issue(op, a, b);
    checks++;
    if (mul_a !== ea || mul_b !== eb || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_issue: mul_a=%h mul_b=%h busy=%b ready=%b, expected %h %h 1 0",
               name, mul_a, mul_b, busy, req_ready, ea, eb);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != LAT + 1) begin
      errors++;
      $display("FAIL %s_busy_cycles: busy for %0d cycles, expected %0d", name, cyc, LAT + 1);
    end
    checks++;
    if (done !== 1'b1 || mul_a !== ea || mul_b !== eb) begin
      errors++;
      $display("FAIL %s_done_rise: done=%b mul_a=%h mul_b=%h, expected 1 %h %h", name, done, mul_a, mul_b, ea, eb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_width: done=%b ready=%b, expected 0 1", name, done, req_ready);
    end
  endtask

  task automatic test_moves();
    req_valid = 1'b1;
    req_op = 2'b10;
    rs = 32'h12345678;
    @(negedge clk);
    checks++;
    if (hi !== 32'h12345678 || done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mthi: hi=%h done=%b ready=%b, expected 12345678 0 1", hi, done, req_ready);
    end
    req_op = 2'b11;
    rs = 32'h9ABCDEF0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h done=%b, expected 12345678 9abcdef0 0", hi, lo, done);
    end
  endtask

  task automatic test_stall();
    int cyc;
    issue(2'b10, 32'hAAAA5555, 32'h0);
    issue(2'b00, 32'h00010000, 32'h00010000);
    req_valid = 1'b1;
    req_op = 2'b10;
    rs = 32'hDEADBEEF;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      checks++;
      if (req_ready !== 1'b0 || hi !== 32'hAAAA5555) begin
        errors++;
        $display("FAIL stall_cycle%0d: ready=%b hi=%h, expected 0 aaaa5555", cyc, req_ready, hi);
      end
      cyc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (hi !== 32'h00000001 || lo !== 32'h0 || cyc != LAT + 1) begin
      errors++;
      $display("FAIL stall_writeback: hi=%h lo=%h cycles=%0d, expected 1 0 %0d", hi, lo, cyc, LAT + 1);
    end
    @(negedge clk);
    checks++;
    if (hi !== 32'h00000001) begin
      errors++;
      $display("FAIL stall_ignored_move: hi=%h, expected 00000001", hi);
    end
  endtask

  task automatic test_reset_mid();
    int dcount;
    issue(2'b11, 32'h00000055, 32'h0);
    issue(2'b00, 32'd5, 32'd7);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0 || mul_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h ready=%b busy=%b mul_a=%h, expected 0 0 1 0 0",
               hi, lo, req_ready, busy, mul_a);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: done pulses=%0d ready=%b, expected 0 1", dcount, req_ready);
    end
    test_mul("rst_follow", 2'b00, 32'd5, 32'd7);
  endtask

  task automatic test_back_to_back();
    int n;
    issue(2'b00, 32'd3, 32'd4);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b ready=%b after %0d cycles, expected 1 1", done, req_ready, n);
    end
    issue(2'b01, 32'hFFFFFFFD, 32'd4);
    checks++;
    if (busy !== 1'b1 || lo !== 32'd12 || hi !== 32'h0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b hi=%h lo=%h, expected 1 0 0000000c", busy, hi, lo);
    end
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT + 2) begin
      errors++;
      $display("FAIL b2b_spacing: %0d cycles between done pulses, expected %0d", n, LAT + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul("unsigned_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    test_mul("signed_mixed", 2'b01, 32'hFFFFFFFF, 32'h00000002);
    test_mul("signed_minmin", 2'b01, 32'h80000000, 32'h80000000);
    test_mul("signed_zero", 2'b01, 32'h00000000, 32'hFFFFFFFB);
    test_moves();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      test_mul("random", 2'($urandom_range(0, 1)), $urandom, $urandom);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
